dff_bank_arbiter: RTL and testbench

// Round-robin arbiter and write sequencer sharing one WIDTH-bit D-flip-flop

---
 rtl/dff_bank_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
//
// Round-robin arbiter and write sequencer in front of one shared WIDTH-bit
// register. Up to N_REQ clients raise a level request together with their
// data. One owner is granted at a time. The owner's data is loaded into the
// shared register exactly one cycle after the grant, and the owner gets a
// one-cycle ack. The grant is held until the owner drops its request, or
// until HOLD_MAX cycles have passed, in which case the grant is taken away
// and err pulses. At least one idle cycle always separates two grants.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      synchronous, active-high reset
//   req_i      per-client level request
//   wr_data_i  client i data at [i*WIDTH +: WIDTH]
//   gnt_o      one-hot grant, all-zero when idle
//   ack_o      one-cycle pulse to the owner when the register has been loaded
//   q_o        shared register contents
//   owner_o    index of the current or most recent owner
//   busy_o     high whenever a grant is in progress
//   err_o      one-cycle pulse when an owner is forcibly released
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*WIDTH-1:0]     wr_data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           ack_o,
  output logic [WIDTH-1:0]           q_o,
  output logic [$clog2(N_REQ)-1:0]   owner_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  state_t             state_q;
  logic [OW-1:0]      ptr_q;
  logic [OW-1:0]      owner_q;
  logic [CW-1:0]      holdCnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic [WIDTH-1:0]   data_q;
  logic               busy_q;
  logic               err_q;

  logic [OW-1:0]      winner_d;
  logic [OW-1:0]      ptr_d;
  logic               ownerReq;
  logic [WIDTH-1:0]   ownerData;

  // Round-robin pick: scanning from the highest offset down to offset 0 and
  // letting later hits overwrite earlier ones leaves the first requester at
  // or after ptr as the winner. The result is only used when some request
  // is present, so the fallback value does not matter.
  function automatic logic [OW-1:0] rrPick(input logic [N_REQ-1:0] req,
                                           input logic [OW-1:0]    ptr);
    logic [OW-1:0] pick;
    int            cand;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (req[OW'(cand)]) begin
        pick = OW'(cand);
      end
    end
    return pick;
  endfunction

  // Winner of the next arbitration, the pointer value that follows the
  // current owner (wrapping), and the current owner's request and data.
  always_comb begin
    winner_d  = rrPick(req_i, ptr_q);
    ptr_d     = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
    ownerReq  = req_i[owner_q];
    ownerData = wr_data_i[int'(owner_q) * WIDTH +: WIDTH];
  end

  // Arbitration FSM with all outputs registered. ack and err are pulses, so
  // they are cleared every cycle unless set below. Every release path
  // advances the pointer past the owner so the others get their turn next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      holdCnt_q <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q <= GRANT;
            gnt_q   <= ONE_HOT_0 << winner_d;
            owner_q <= winner_d;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (ownerReq) begin
            data_q    <= ownerData;
            ack_q     <= gnt_q;
            holdCnt_q <= '0;
            state_q   <= HOLD;
          end else begin
            // Owner withdrew before the load: abort without touching q.
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (!ownerReq) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (holdCnt_q == CW'(HOLD_MAX - 1)) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            holdCnt_q <= holdCnt_q + CW'(1);
          end
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign q_o     = data_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Self-checking bench for dff_bank_arbiter (N_REQ=4, WIDTH=8, HOLD_MAX=16).
// A transaction-level reference model follows the arbitration rules with
// plain integers (current owner, round-robin next index, edges held since
// ack) and pushes the expected ack / err pulses into a scoreboard queue.
// A monitor on the falling edge pops and compares whenever the DUT presents
// a pulse, and also compares grant, busy, q and owner against the model.
// ---------------------------------------------------------------------------
module tb_dff_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int HM = 16;
  localparam int EV_ACK = 0;
  localparam int EV_ERR = 1;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wrData;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [W-1:0]     q;
  logic [1:0]       owner;
  logic             busy;
  logic             err;

  typedef struct {
    int         kind;
    int         who;
    logic [W-1:0] data;
  } event_t;

  event_t scoreQ[$];
  int     grantLog[$];
  int     total = 0;
  int     bad = 0;
  int     ackSeen = 0;
  int     errSeen = 0;

  // Reference model state
  int           curOwner = -1;
  int           rrNext = 0;
  int           heldEdges = 0;
  bit           acked = 1'b0;
  int           expOwner = 0;
  logic [W-1:0] expQ = '0;

  // Monitor scratch
  logic [N-1:0] prevGnt = '0;
  logic [N-1:0] monExpGnt;
  event_t       monEv;

  dff_bank_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .HOLD_MAX (HM)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .wr_data_i (wrData),
    .gnt_o     (gnt),
    .ack_o     (ack),
    .q_o       (q),
    .owner_o   (owner),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int onehotIdx(input logic [N-1:0] v);
    int idx;
    int cnt;
    idx = -1;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (v[k] === 1'b1) begin
        idx = k;
        cnt++;
      end
    end
    if (cnt != 1) idx = -1;
    return idx;
  endfunction

  function automatic bit reqBit(input int i);
    return ((req >> i) & N'(1)) != '0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic failLine(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    total++;
    bad++;
    $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input int cycles);
    req = r;
    repeat (cycles) tick();
  endtask

  task automatic setData(input int i, input logic [W-1:0] d);
    wrData[i*W +: W] = d;
  endtask

  // Waits (bounded) for an ack pulse and returns the acked index, -1 on timeout.
  task automatic waitAck(output int who);
    who = -1;
    for (int t = 0; t < 20 && who < 0; t++) begin
      @(negedge clk);
      if (ack !== '0) who = onehotIdx(ack);
    end
    if (who < 0) failLine("ack_timeout", 64'(0), 64'(1));
  endtask

  // Reference model: one step per rising edge, driven by the sampled inputs.
  // A grant lives from the edge it is issued until the owner's request is
  // seen low, or until HM edges after the load edge have seen it still high.
  always @(posedge clk) begin
    if (rst) begin
      curOwner = -1;
      rrNext   = 0;
      expQ     = '0;
      expOwner = 0;
      acked    = 1'b0;
    end else if (curOwner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (curOwner < 0 && reqBit((rrNext + k) % N)) begin
          curOwner = (rrNext + k) % N;
          expOwner = curOwner;
          acked    = 1'b0;
        end
      end
    end else if (!reqBit(curOwner)) begin
      rrNext   = (curOwner + 1) % N;
      curOwner = -1;
    end else if (!acked) begin
      expQ      = W'(wrData >> (curOwner * W));
      acked     = 1'b1;
      heldEdges = 0;
      scoreQ.push_back('{EV_ACK, curOwner, expQ});
    end else begin
      heldEdges++;
      if (heldEdges == HM) begin
        scoreQ.push_back('{EV_ERR, curOwner, expQ});
        rrNext   = (curOwner + 1) % N;
        curOwner = -1;
      end
    end
  end

  // Monitor: compares level outputs against the model every cycle and
  // consumes scoreboard entries whenever the DUT shows an ack or err pulse.
  // Anything the model expected but the DUT did not show is reported.
  always @(negedge clk) begin
    monExpGnt = (curOwner >= 0) ? (N'(1) << curOwner) : '0;
    checkOutput("gnt", 64'(gnt), 64'(monExpGnt));
    checkOutput("busy", 64'(busy), 64'(curOwner >= 0));
    checkOutput("q", 64'(q), 64'(expQ));
    checkOutput("owner", 64'(owner), 64'(expOwner));
    if (prevGnt == '0 && gnt != '0) grantLog.push_back(onehotIdx(gnt));
    prevGnt = gnt;
    if (ack !== '0) begin
      ackSeen++;
      if (scoreQ.size() != 0 && scoreQ[0].kind == EV_ACK) begin
        monEv = scoreQ.pop_front();
        checkOutput("ack_who", 64'(onehotIdx(ack)), 64'(monEv.who));
        checkOutput("ack_data", 64'(q), 64'(monEv.data));
      end else begin
        failLine("ack_unexpected", 64'(ack), 64'(0));
      end
    end
    if (err !== 1'b0) begin
      errSeen++;
      if (scoreQ.size() != 0 && scoreQ[0].kind == EV_ERR) begin
        monEv = scoreQ.pop_front();
        checkOutput("err_who", 64'(owner), 64'(monEv.who));
      end else begin
        failLine("err_unexpected", 64'(err), 64'(0));
      end
    end
    while (scoreQ.size() != 0) begin
      monEv = scoreQ.pop_front();
      failLine("missing_pulse", 64'(0), 64'(monEv.kind + 1));
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int who;
    int base;
    int errBefore;
    int ackBefore;

    rst    = 1'b1;
    req    = '0;
    wrData = '0;

    // Reset held for two edges
    tick();
    tick();
    checkOutput("rst_gnt", 64'(gnt), 64'(0));
    checkOutput("rst_ack", 64'(ack), 64'(0));
    checkOutput("rst_q", 64'(q), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_owner", 64'(owner), 64'(0));
    rst = 1'b0;

    // Single requester 2, drop one cycle after ack, then pointer sits at 3
    $display("[TB] single request from client 2");
    setData(2, 8'hA5);
    setData(0, 8'h11);
    setData(3, 8'h33);
    req = 4'b0100;
    waitAck(who);
    checkOutput("t2_owner", 64'(who), 64'(2));
    checkOutput("t2_q", 64'(q), 64'hA5);
    tick();
    req = '0;
    tick();
    checkOutput("t2_gnt_released", 64'(gnt), 64'(0));
    req = 4'b1001;
    waitAck(who);
    checkOutput("t2_next_from_ptr", 64'(who), 64'(3));
    applyStimulus('0, 3);

    // All four requesting, each drops after its ack and re-raises
    $display("[TB] round-robin with all clients requesting");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) setData(i, W'($urandom));
    base = grantLog.size();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitAck(who);
      if (who >= 0) begin
        tick();
        req[who] = 1'b0;
        setData(who, W'($urandom));
        tick();
        req[who] = 1'b1;
      end
    end
    applyStimulus('0, 4);
    if (grantLog.size() < base + 5) begin
      failLine("rr_grant_count", 64'(grantLog.size() - base), 64'(5));
    end else begin
      for (int k = 0; k < 5; k++) begin
        checkOutput("rr_order", 64'(grantLog[base + k]), 64'(k % N));
      end
    end

    // Client 1 holds its request past the hold limit
    $display("[TB] hold limit on client 1");
    setData(1, 8'h5C);
    errBefore = errSeen;
    applyStimulus(4'b0010, 2 * HM + 8);
    applyStimulus('0, 3);
    checkOutput("hold_timeout_errs", 64'(errSeen - errBefore), 64'(2));

    // Client 3 withdraws while in the grant cycle
    $display("[TB] aborted request from client 3");
    setData(3, 8'hE7);
    ackBefore = ackSeen;
    applyStimulus(4'b1000, 1);
    applyStimulus('0, 3);
    checkOutput("abort_no_ack", 64'(ackSeen - ackBefore), 64'(0));
    checkOutput("abort_q", 64'(q), 64'(expQ));

    // Reset while client 2 holds the grant; pointer must restart at 0
    $display("[TB] reset during hold");
    setData(2, 8'h3C);
    applyStimulus(4'b0100, 4);
    rst = 1'b1;
    tick();
    checkOutput("midrst_gnt", 64'(gnt), 64'(0));
    checkOutput("midrst_ack", 64'(ack), 64'(0));
    checkOutput("midrst_q", 64'(q), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_err", 64'(err), 64'(0));
    checkOutput("midrst_owner", 64'(owner), 64'(0));
    rst = 1'b0;
    req = 4'b1010;
    waitAck(who);
    checkOutput("midrst_ptr_zero", 64'(who), 64'(1));
    applyStimulus('0, 3);

    // Randomized request toggling with occasional resets
    $display("[TB] randomized phase");
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(3) == 0) req[r] = ~req[r];
        if (req[r] == 1'b0) setData(r, W'($urandom));
      end
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus('0, 4);

    checkOutput("scoreboard_drained", 64'(scoreQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
